// File: rtl/uart_tx_queue.sv
// Byte FIFO feeding a UART transmitter through a one-cycle launch strobe.
// If the transmitter never acknowledges a launch, the same byte is strobed again.
module uart_tx_queue #(
   parameter int unsigned DEPTH       = 16,
   parameter int unsigned ACK_TIMEOUT = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [7:0]               wr_data,
   input  logic                     wr_valid,
   output logic                     wr_ready,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty,
   output logic                     full,
   output logic                     overflow,
   output logic [7:0]               tx_d,
   output logic                     tx_send,
   input  logic                     tx_rdy
);

   localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned CW = AW + 1;
   localparam int unsigned TW = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;

   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("uart_tx_queue: DEPTH must be a power of two >= 2");
   end
   if (ACK_TIMEOUT < 1) begin : g_bad_timeout
      $error("uart_tx_queue: ACK_TIMEOUT must be >= 1");
   end

   typedef enum logic [1:0] {IDLE, PULSE, ACK, BUSY} state_t;

   state_t        state, state_nxt;
   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] head, tail;
   logic [TW-1:0] tmo, tmo_nxt;
   logic [7:0]    tx_d_nxt;
   logic          tx_send_nxt;
   logic          wr_acc_c;
   logic          pop_c;

   assign full     = (count == CW'(DEPTH));
   assign empty    = (count == '0);
   assign wr_ready = !full;
   assign wr_acc_c = wr_valid && !full;

   // Launch FSM: next state, strobe and byte selection
   always_comb begin
      state_nxt   = state;
      tx_send_nxt = 1'b0;
      tx_d_nxt    = tx_d;
      tmo_nxt     = tmo;
      pop_c       = 1'b0;
      case (state)
         IDLE: begin
            if (!empty && tx_rdy) begin
               pop_c       = 1'b1;
               tx_d_nxt    = mem[head];
               tx_send_nxt = 1'b1;
               state_nxt   = PULSE;
            end
         end
         PULSE: begin
            tmo_nxt   = '0;
            state_nxt = ACK;
         end
         ACK: begin
            if (!tx_rdy) begin
               state_nxt = BUSY;
            end else if (tmo == TW'(ACK_TIMEOUT - 1)) begin
               tx_send_nxt = 1'b1;
               state_nxt   = PULSE;
            end else begin
               tmo_nxt = tmo + TW'(1);
            end
         end
         BUSY: begin
            if (tx_rdy) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         tx_send <= 1'b0;
         tx_d    <= 8'h00;
         tmo     <= '0;
      end else begin
         state   <= state_nxt;
         tx_send <= tx_send_nxt;
         tx_d    <= tx_d_nxt;
         tmo     <= tmo_nxt;
      end
   end

   // Pointers and occupancy; a write rejected while full raises overflow
   always_ff @(posedge clk) begin
      if (rst) begin
         head     <= '0;
         tail     <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (wr_acc_c) tail <= tail + AW'(1);
         if (pop_c)    head <= head + AW'(1);
         count    <= count + CW'(wr_acc_c) - CW'(pop_c);
         overflow <= wr_valid && full;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst && wr_acc_c) mem[tail] <= wr_data;
   end

endmodule

// File: doc/uart_tx_queue.md
UART_TX_QUEUE -- requirements
Module: uart_tx_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entry count; power of two, >= 2; otherwise $error at elaboration.
REQ-002 SHALL have parameter ACK_TIMEOUT, default 4, cycles to wait in ACK for tx_rdy to fall before re-pulsing; >= 1.
REQ-003 SHALL use clock clk and reset rst, synchronous, active-high.
REQ-004 SHALL have ports, one per line:
  clk       input   1                 system clock
  rst       input   1                 synchronous active-high reset
  wr_data   input   8                 byte to enqueue
  wr_valid  input   1                 wr_data valid this cycle
  wr_ready  output  1                 queue can accept a write this cycle
  count     output  $clog2(DEPTH)+1   bytes stored, excluding byte in flight
  empty     output  1                 count == 0
  full      output  1                 count == DEPTH
  overflow  output  1                 one-cycle pulse: write attempted while full
  tx_d      output  8                 byte presented to downstream transmitter
  tx_send   output  1                 rising-edge launch strobe to transmitter
  tx_rdy    input   1                 transmitter idle and ready for a launch

Function
REQ-005 SHALL accept a write on the clk edge where wr_valid && wr_ready; the byte is stored at the tail and count increments.
REQ-006 SHALL drive wr_ready = !full, combinationally from registered count.
REQ-007 SHALL ignore wr_valid while full, even if a pop occurs on the same edge, and pulse overflow high for exactly one cycle per rejected edge.
REQ-008 SHALL leave count unchanged when an accepted write and a pop occur on the same edge.
REQ-009 SHALL wrap head and tail pointers modulo DEPTH with no gap or duplicate entry.
REQ-010 SHALL implement launch FSM states IDLE, PULSE, ACK and BUSY.
REQ-011 IDLE: if count > 0 && tx_rdy at an edge, SHALL load tx_d from the head, pop (head++, count--), set tx_send <= 1 and go to PULSE; otherwise it stays in IDLE.
REQ-012 PULSE: SHALL set tx_send <= 0 at the next edge, clear the timeout counter and go to ACK, so tx_send is high for exactly one cycle.
REQ-013 ACK: if !tx_rdy, SHALL go to BUSY.
REQ-014 ACK: if tx_rdy stays high for ACK_TIMEOUT cycles, SHALL set tx_send <= 1 and return to PULSE with the same tx_d (re-pulse without popping).
REQ-015 BUSY: SHALL return to IDLE at the first edge where tx_rdy == 1.
REQ-016 SHALL hold tx_d stable from the launch edge until the FSM leaves BUSY.
REQ-017 SHALL guarantee tx_send is low for at least one cycle between consecutive rising edges.
REQ-018 Latency: a write accepted into an empty queue at edge E, with tx_rdy high, SHALL produce tx_send = 1 in the cycle after edge E+1.
REQ-019 Back-to-back: the next launch SHALL occur on the edge where BUSY sees tx_rdy = 1 plus one IDLE edge, i.e. no more than 2 cycles after tx_rdy rises.
REQ-020 SHALL preserve byte order: bytes leave on tx_d in exact write order.

Reset
REQ-021 While rst is high at an edge, SHALL set FSM=IDLE, head=tail=0, count=0, tx_send=0, tx_d=8'h00 and overflow=0, and SHALL ignore writes.
REQ-022 Reset values: empty=1, full=0, wr_ready=1 from the first cycle after reset.
REQ-023 Reset mid-transmission SHALL discard all queued bytes and the in-flight byte; no launch occurs until a new write is accepted.
REQ-024 FIFO storage array SHALL need no reset; only pointers and count are cleared.

Verification
REQ-025 Reset, then write 8'hA5 with tx_rdy=1 -> tx_send high for exactly 1 cycle, with tx_d=8'hA5 in the cycle after edge E+1.
REQ-026 Write 0x01..0x10 back-to-back with DEPTH=16 and tx_rdy low -> full=1 and wr_ready=0; a 17th write pulses overflow once and count stays 16.
REQ-027 Connect to the in-codebase transmitter (DIVIDER=4) and enqueue 0x55, 0x00, 0xFF -> tx line shows three frames in that order, each start bit 0 and stop bit 1.
REQ-028 Hold tx_rdy high and never drop it after a launch -> re-pulse after ACK_TIMEOUT=4 cycles with the same tx_d; count is not decremented again.
REQ-029 Fill to 20 writes with DEPTH=16 while draining, crossing pointer wrap -> output sequence equals the accepted input sequence.
REQ-030 Assert rst while in BUSY with 5 bytes queued -> next cycle count=0, empty=1, tx_send=0, and no further launches.
